// File: rtl/router_pkg.sv
// Types and constants shared by the ingress buffer and the 4-way address router.
package router_pkg;

  localparam int NUM_DEST = 4;
  localparam int DEST_W   = 2;

  typedef logic [DEST_W-1:0] dest_t;

  // A buffered entry is {addr, data}, with addr in the MSBs.
  function automatic int entry_width(input int data_width);
    return data_width + DEST_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous flush. The head entry is presented combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;

endmodule

// File: rtl/router_ingress_buffer.sv
// Ingress FIFO in front of the address router: in-order, stall-gated pop into a registered din/addr stage.
module router_ingress_buffer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [1:0]              in_addr,
  input  logic                    flush,
  input  logic [NUM_DEST-1:0]     dest_stall,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    din_en,
  output logic [1:0]              addr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    dest_t                 addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                w_wentry;
  entry_t                w_head;
  logic [CW-1:0]         w_count;
  logic                  w_push;
  logic                  w_pop;

  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_din_en;
  dest_t                 r_addr;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = (w_count < DEPTH_C) & ~flush;
  assign w_push   = in_valid & in_ready;
  // Head-of-line: only the head entry is ever considered, so nothing bypasses a stalled head.
  assign w_pop    = (w_count != '0) & ~dest_stall[w_head.addr] & ~flush;

  assign w_wentry.addr = in_addr;
  assign w_wentry.data = in_data;

  sync_fifo #(
    .WIDTH (entry_width(DATA_WIDTH)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .wdata (w_wentry),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din    <= '0;
      r_din_en <= 1'b0;
      r_addr   <= '0;
    end else if (w_pop) begin
      r_din    <= w_head.data;
      r_din_en <= 1'b1;
      r_addr   <= w_head.addr;
    end else begin
      // addr keeps its last value on idle cycles.
      r_din    <= '0;
      r_din_en <= 1'b0;
    end
  end

  assign din    = r_din;
  assign din_en = r_din_en;
  assign addr   = r_addr;
  assign count  = w_count;

endmodule
